// File: rtl/hm01b0_capture.sv
// HM01B0 parallel camera receiver: samples the pins, tracks frame/line position and
// emits one coordinate-tagged pixel per cycle plus frame/line markers and length-error flags.
module hm01b0_capture #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  pixdata,
    input  logic        hsync,
    input  logic        vsync,
    output logic        pix_valid,
    output logic [7:0]  pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        SKIP   = 2'd3
    } state_t;

    localparam logic [15:0] WIDTH_W  = 16'(WIDTH);
    localparam logic [15:0] HEIGHT_W = 16'(HEIGHT);
    localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);

    logic [7:0]  s_pixdata;
    logic        s_hsync;
    logic        s_vsync;
    logic        s_hsync_d;
    logic        s_vsync_d;

    state_t      state;
    logic [15:0] x;
    logic [15:0] y;

    logic        vs_rise;
    logic        vs_fall;
    logic        hs_fall;
    logic        pix_cycle;
    logic        start_now;
    logic        capture;
    logic        in_active;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    logic        take;
    logic        line_close;
    logic        frame_close;
    logic [15:0] y_closed;
    logic [15:0] lines;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Pin sampling keeps running through reset so SYNC judges the true vsync level.
    always_ff @(posedge clock) begin
        s_pixdata <= pixdata;
        s_hsync   <= hsync;
        s_vsync   <= vsync;
        s_hsync_d <= s_hsync;
        s_vsync_d <= s_vsync;
    end

    assign vs_rise     = s_vsync & ~s_vsync_d;
    assign vs_fall     = ~s_vsync & s_vsync_d;
    assign hs_fall     = ~s_hsync & s_hsync_d;
    assign pix_cycle   = s_hsync & s_vsync;
    assign start_now   = (state == IDLE) && vs_rise && enable;
    assign in_active   = (state == ACTIVE);
    assign capture     = start_now | in_active;
    // The frame-opening cycle counts from (0,0) even though x/y still hold the old frame.
    assign cur_x       = start_now ? 16'd0 : x;
    assign cur_y       = start_now ? 16'd0 : y;
    assign take        = capture && pix_cycle && (cur_x < WIDTH_W) && (cur_y < HEIGHT_W);
    assign line_close  = in_active && hs_fall;
    assign frame_close = in_active && vs_fall;
    // A line closing in the same cycle as the frame is counted before the frame check.
    assign y_closed    = line_close ? sat_inc(cur_y) : cur_y;
    assign lines       = y_closed + {15'd0, s_hsync};

    // Capture FSM, position counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SYNC;
            x           <= 16'd0;
            y           <= 16'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 8'd0;
            pix_x       <= 16'd0;
            pix_y       <= 16'd0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pix_valid   <= take;
            pix_data    <= take ? s_pixdata : 8'd0;
            pix_x       <= take ? cur_x : 16'd0;
            pix_y       <= take ? cur_y : 16'd0;
            frame_start <= take && (cur_x == 16'd0) && (cur_y == 16'd0);
            line_end    <= take && (cur_x == X_LAST);
            frame_done  <= frame_close;
            line_err    <= line_err | (line_close && (cur_x != 16'd0) && (cur_x != WIDTH_W));
            frame_err   <= frame_err | (frame_close && (lines != HEIGHT_W));

            if (line_close) begin
                x <= 16'd0;
                y <= y_closed;
            end else if (capture && pix_cycle) begin
                x <= sat_inc(cur_x);
                y <= cur_y;
            end else if (start_now) begin
                x <= 16'd0;
                y <= 16'd0;
            end else begin
                x <= x;
                y <= y;
            end

            case (state)
                SYNC:    state <= s_vsync ? SYNC : IDLE;
                IDLE: begin
                    if (vs_rise) begin
                        state <= enable ? ACTIVE : SKIP;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACTIVE:  state <= vs_fall ? IDLE : ACTIVE;
                SKIP:    state <= vs_fall ? IDLE : SKIP;
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_hm01b0_capture.sv
// Directed bench for hm01b0_capture on a reduced 16x8 geometry (4-cycle hblank, 2-line vblank).
module tb_hm01b0_capture;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int HB  = 4;
    localparam int VBC = 2 * (W + HB);

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  pixdata;
    logic        hsync;
    logic        vsync;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        frame_start;
    logic        line_end;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    int   n_start   = 0;
    int   n_le      = 0;
    int   n_done    = 0;
    int   n_bad_fs  = 0;
    int   n_bad_le  = 0;
    int   start_cyc = 0;
    int   last_cyc  = 0;
    logic ferr_at_done = 1'b0;
    int   t_first = 0;
    int   t_last  = 0;
    int   eb, gb, s0, le0, d0, bfs0, ble0;

    hm01b0_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .pixdata(pixdata), .hsync(hsync), .vsync(vsync),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_end(line_end), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: records every emitted pixel and marker on the falling edge.
    always @(negedge clock) begin
        if (pix_valid) begin
            got_q.push_back({pix_y, pix_x, pix_data});
            last_cyc <= cyc;
        end
        if (frame_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            if (!(pix_valid && pix_x == 16'd0 && pix_y == 16'd0)) n_bad_fs <= n_bad_fs + 1;
        end
        if (line_end) begin
            n_le <= n_le + 1;
            if (!(pix_valid && pix_x == 16'(W - 1))) n_bad_le <= n_bad_le + 1;
        end
        if (frame_done) begin
            n_done       <= n_done + 1;
            ferr_at_done <= frame_err;
        end
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clock);
        #1;
        vsync   = v;
        hsync   = h;
        pixdata = d;
    endtask

    task automatic drive_line(input int npix, input int yl, input bit cap);
        logic [7:0] d;
        for (int i = 0; i < npix; i++) begin
            d = 8'(i + yl);
            drive(1'b1, 1'b1, d);
            if (cap && i < W && yl < H) begin
                exp_q.push_back({16'(yl), 16'(i), d});
                if (i == 0 && yl == 0) t_first = cyc;
                t_last = cyc;
            end
        end
        for (int i = 0; i < HB; i++) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drive_frame(input int nlines, input int sp_line, input int sp_len,
                               input bit cap, input int raise_line, input bit vb_hs);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            if (l == raise_line) enable = 1'b1;
            drive_line((l == sp_line) ? sp_len : W, l, cap);
        end
        for (int i = 0; i < VBC; i++) drive(1'b0, vb_hs && (i >= 4) && (i < 10), 8'hEE);
    endtask

    task automatic mark();
        eb   = exp_q.size();
        gb   = got_q.size();
        s0   = n_start;
        le0  = n_le;
        d0   = n_done;
        bfs0 = n_bad_fs;
        ble0 = n_bad_le;
    endtask

    function automatic int count_diff();
        int d = 0;
        for (int i = 0; i < exp_q.size() - eb; i++)
            if (gb + i >= got_q.size() || got_q[gb + i] !== exp_q[eb + i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        @(negedge clock);
        n_cmp++;
        if ({pix_valid, frame_start, line_end, frame_done, line_err, frame_err, pix_data, pix_x, pix_y} !== 46'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0",
                {pix_valid, frame_start, line_end, frame_done, line_err, frame_err, pix_data, pix_x, pix_y});
        end
        reset = 1'b0;
        mark();
        drive_frame(H, -1, 0, 1'b0, -1, 1'b0);
        n_cmp++; if (got_q.size() - gb !== 0) begin n_fail++; $display("FAIL partial_frame_pixels: got %0d required 0", got_q.size() - gb); end
        n_cmp++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL partial_frame_done: got %0d required 0", n_done - d0); end
        mark();
        drive_frame(H, -1, 0, 1'b1, -1, 1'b0);
        n_cmp++; if (got_q.size() - gb !== W * H) begin n_fail++; $display("FAIL first_frame_count: got %0d required %0d", got_q.size() - gb, W * H); end
        n_cmp++; if (count_diff() !== 0) begin n_fail++; $display("FAIL first_frame_data: got %0d bad pixels required 0", count_diff()); end
        n_cmp++; if (n_start - s0 !== 1 || n_bad_fs - bfs0 !== 0) begin n_fail++; $display("FAIL first_frame_start: got %0d starts %0d misplaced required 1/0", n_start - s0, n_bad_fs - bfs0); end
        n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL first_frame_done: got %0d required 1", n_done - d0); end
        n_cmp++; if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL first_frame_errs: got %b required 00", {line_err, frame_err}); end
    endtask

    task automatic test_ramp();
        mark();
        drive_frame(H, -1, 0, 1'b1, -1, 1'b0);
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * H) begin n_fail++; $display("FAIL ramp_data: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * H); end
        n_cmp++; if (start_cyc - t_first !== 2) begin n_fail++; $display("FAIL ramp_first_latency: got %0d required 2", start_cyc - t_first); end
        n_cmp++; if (last_cyc - t_last !== 2) begin n_fail++; $display("FAIL ramp_last_latency: got %0d required 2", last_cyc - t_last); end
        n_cmp++; if (n_le - le0 !== H || n_bad_le - ble0 !== 0) begin n_fail++; $display("FAIL ramp_line_end: got %0d ends %0d misplaced required %0d/0", n_le - le0, n_bad_le - ble0, H); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        mark();
        drive_frame(H, -1, 0, 1'b0, 3, 1'b0);
        n_cmp++; if (got_q.size() - gb !== 0) begin n_fail++; $display("FAIL disabled_pixels: got %0d required 0", got_q.size() - gb); end
        n_cmp++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL disabled_done: got %0d required 0", n_done - d0); end
        mark();
        drive_frame(H, -1, 0, 1'b1, -1, 1'b0);
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * H) begin n_fail++; $display("FAIL reenabled_frame: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * H); end
        n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL reenabled_done: got %0d required 1", n_done - d0); end
    endtask

    task automatic test_line_len();
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL line_err_before: got %b required 0", line_err); end
        mark();
        drive_frame(H, 2, W - 1, 1'b1, -1, 1'b0);
        n_cmp++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err: got %b required 1", line_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL short_line_frame_err: got %b required 0", frame_err); end
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * H - 1) begin n_fail++; $display("FAIL short_line_data: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * H - 1); end
        mark();
        drive_frame(H, 3, W + 1, 1'b1, -1, 1'b0);
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * H) begin n_fail++; $display("FAIL long_line_drop: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * H); end
        n_cmp++; if (n_le - le0 !== H) begin n_fail++; $display("FAIL long_line_ends: got %0d required %0d", n_le - le0, H); end
    endtask

    task automatic test_frame_len();
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_before: got %b required 0", frame_err); end
        mark();
        drive_frame(H - 1, -1, 0, 1'b1, -1, 1'b1);
        n_cmp++; if (frame_err !== 1'b1 || ferr_at_done !== 1'b1) begin n_fail++; $display("FAIL short_frame_err: got %b at_done %b required 1/1", frame_err, ferr_at_done); end
        n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL short_frame_done: got %0d required 1", n_done - d0); end
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * (H - 1)) begin n_fail++; $display("FAIL short_frame_data: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * (H - 1)); end
        n_cmp++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL line_err_sticky: got %b required 1", line_err); end
    endtask

    task automatic test_reset_mid();
        int da;
        da = n_done;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < 3; l++) drive_line(W, l, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'(i + 3));
        @(negedge clock);
        n_cmp++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b required 1", pix_valid); end
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h08);
        @(negedge clock);
        n_cmp++;
        if ({pix_valid, frame_start, line_end, frame_done, line_err, frame_err, pix_data, pix_x, pix_y} !== 46'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h required 0",
                {pix_valid, frame_start, line_end, frame_done, line_err, frame_err, pix_data, pix_x, pix_y});
        end
        reset = 1'b0;
        for (int i = 6; i < W; i++) drive(1'b1, 1'b1, 8'(i + 3));
        for (int i = 0; i < HB; i++) drive(1'b1, 1'b0, 8'h00);
        for (int l = 4; l < H; l++) drive_line(W, l, 1'b0);
        for (int i = 0; i < VBC; i++) drive(1'b0, 1'b0, 8'h00);
        n_cmp++; if (n_done - da !== 0) begin n_fail++; $display("FAIL aborted_done: got %0d required 0", n_done - da); end
        mark();
        drive_frame(H, -1, 0, 1'b1, -1, 1'b0);
        n_cmp++; if (count_diff() !== 0 || got_q.size() - gb !== W * H) begin n_fail++; $display("FAIL resumed_frame: got %0d bad of %0d required 0 of %0d", count_diff(), got_q.size() - gb, W * H); end
        n_cmp++; if (n_done - d0 !== 1 || n_start - s0 !== 1) begin n_fail++; $display("FAIL resumed_markers: got done %0d start %0d required 1/1", n_done - d0, n_start - s0); end
        n_cmp++; if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL resumed_errs: got %b required 00", {line_err, frame_err}); end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        hsync   = 1'b0;
        vsync   = 1'b1;
        pixdata = 8'h00;
        test_reset();
        test_ramp();
        test_enable();
        test_line_len();
        test_frame_len();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
